// File: rtl/midi_pkg.sv
// midi_pkg: shared MIDI status constants, message word type and FSM state encodings.
package midi_pkg;
    localparam int MIDI_BAUD = 31250;
    localparam logic [7:0] ST_NOTE_OFF = 8'h80;
    localparam logic [7:0] ST_PROG     = 8'hC0;
    localparam logic [7:0] ST_CHPRESS  = 8'hD0;
    localparam logic [7:0] ST_SYS      = 8'hF0;
    localparam logic [7:0] ST_RT       = 8'hF8;
    typedef logic [23:0] midi_msg_t;
    typedef enum logic [2:0] {U_IDLE, U_START, U_DATA, U_STOP, U_WAIT_HIGH} uart_state_t;
    typedef enum logic [1:0] {WAIT_STATUS, WAIT_D1, WAIT_D2} parse_state_t;
    // Program change and channel pressure carry a single data byte.
    function automatic logic is_two_byte(input logic [7:0] st);
        return st >= ST_PROG && st < ST_CHPRESS + 8'h10;
    endfunction
endpackage

// File: rtl/midi_uart_rx.sv
// midi_uart_rx: synchronised oversampling UART receiver, emits byte_vld / frame_err pulses.
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = MIDI_BAUD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       midi_rx,
    output logic [7:0] data,
    output logic       byte_vld,
    output logic       frame_err
);
    localparam int BIT_DIV = CLK_HZ / BAUD;
    localparam int CW = $clog2(BIT_DIV);
    localparam logic [CW-1:0] FULL = CW'(BIT_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(BIT_DIV / 2 - 1);
    uart_state_t state, nxt;
    logic sync1, rx, rx_d;
    logic [CW-1:0] cnt;
    logic [2:0] idx;
    logic [7:0] shreg;
    logic tick, fall;
    assign tick = (state == U_START) ? cnt == HALF : cnt == FULL;
    assign fall = rx_d && !rx;
    assign data = shreg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rx    <= 1'b1;
            rx_d  <= 1'b1;
            state <= U_IDLE;
        end else begin
            sync1 <= midi_rx;
            rx    <= sync1;
            rx_d  <= rx;
            state <= nxt;
        end
    end
    always_comb begin
        nxt = state;
        case (state)
            U_IDLE:      nxt = fall ? U_START : U_IDLE;
            U_START:     nxt = !tick ? U_START : (rx ? U_IDLE : U_DATA);
            U_DATA:      nxt = (tick && idx == 3'd7) ? U_STOP : U_DATA;
            U_STOP:      nxt = !tick ? U_STOP : (rx ? U_IDLE : U_WAIT_HIGH);
            U_WAIT_HIGH: nxt = rx ? U_IDLE : U_WAIT_HIGH;
            default:     nxt = U_IDLE;
        endcase
    end
    always_comb begin
        byte_vld  = state == U_STOP && tick && rx;
        frame_err = state == U_STOP && tick && !rx;
    end
    // The period counter restarts at every sample point and idles at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            cnt <= (tick || state == U_IDLE || state == U_WAIT_HIGH) ? '0 : cnt + 1'b1;
            idx <= (state == U_START) ? 3'd0 : (state == U_DATA && tick) ? idx + 3'd1 : idx;
            if (state == U_DATA && tick) shreg <= {rx, shreg[7:1]};
        end
    end
endmodule

// File: rtl/midi_rx_parser.sv
// midi_rx_parser: assembles MIDI channel-voice messages (with running status)
// from the serial line into a 24-bit word with a one-cycle ready strobe.
module midi_rx_parser
    import midi_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = MIDI_BAUD
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        MIDI_RX,
    output logic [23:0] MIDI_MSG,
    output logic        MIDI_MSG_RDY,
    output logic        FRAME_ERR
);
    logic [7:0] b, rs, d1;
    logic vld, rs_vld, is_ch, is_sys, take_d1, take_d2, emit;
    midi_msg_t msg_nxt;
    parse_state_t state, nxt;
    midi_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_uart (
        .clk(CLK), .rst_n(RST_N), .midi_rx(MIDI_RX),
        .data(b), .byte_vld(vld), .frame_err(FRAME_ERR)
    );
    assign is_ch   = b >= ST_NOTE_OFF && b < ST_SYS;
    assign is_sys  = b >= ST_SYS && b < ST_RT;
    assign take_d1 = !b[7] && (state == WAIT_D1 || (state == WAIT_STATUS && rs_vld));
    assign take_d2 = !b[7] && state == WAIT_D2;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= WAIT_STATUS;
        else        state <= nxt;
    end
    // Real-time bytes match none of the branches and leave everything untouched.
    always_comb begin
        nxt = state;
        if (vld)
            nxt = is_ch   ? WAIT_D1 :
                  is_sys  ? WAIT_STATUS :
                  take_d1 ? (is_two_byte(rs) ? WAIT_STATUS : WAIT_D2) :
                  take_d2 ? WAIT_STATUS : state;
    end
    always_comb begin
        emit    = vld && (take_d2 || (take_d1 && is_two_byte(rs)));
        msg_nxt = take_d2 ? {rs, d1, b} : {rs, b, 8'h00};
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rs           <= '0;
            rs_vld       <= 1'b0;
            d1           <= '0;
            MIDI_MSG     <= '0;
            MIDI_MSG_RDY <= 1'b0;
        end else begin
            MIDI_MSG_RDY <= emit;
            if (emit) MIDI_MSG <= msg_nxt;
            if (vld && is_ch) begin
                rs     <= b;
                rs_vld <= 1'b1;
            end
            if (vld && is_sys) rs_vld <= 1'b0;
            if (vld && take_d1) d1 <= b;
        end
    end
endmodule

// File: tb/tb_midi_rx_parser.sv
// tb_midi_rx_parser: directed serial byte vectors with hand-computed message words.
module tb_midi_rx_parser;
    localparam int BD = 16;
    localparam int CLK_HZ = 31250 * BD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic midi_rx = 1'b1;
    logic [23:0] midi_msg;
    logic midi_msg_rdy, frame_err;

    midi_rx_parser #(.CLK_HZ(CLK_HZ), .BAUD(31250)) dut (
        .CLK(clk), .RST_N(rst_n), .MIDI_RX(midi_rx),
        .MIDI_MSG(midi_msg), .MIDI_MSG_RDY(midi_msg_rdy), .FRAME_ERR(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int vectors = 0, miscompares = 0;
    logic [23:0] got[$];
    int fe_cnt = 0, first_rdy_cyc = -1, last_start = 0;
    logic prev_rdy = 1'b0, back_to_back = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (midi_msg_rdy) begin
                if (got.size() == 0) first_rdy_cyc = cyc;
                got.push_back(midi_msg);
            end
            if (midi_msg_rdy && prev_rdy) back_to_back = 1'b1;
            if (frame_err) fe_cnt++;
        end
        prev_rdy = midi_msg_rdy;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        @(negedge clk);
        last_start = cyc;
        midi_rx = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            midi_rx = b[i];
            repeat (BD) @(negedge clk);
        end
        midi_rx = stop;
        repeat (BD) @(negedge clk);
        midi_rx = 1'b1;
        repeat (BD) @(negedge clk);
    endtask

    task automatic clear_log();
        got.delete();
        fe_cnt = 0;
        first_rdy_cyc = -1;
    endtask

    typedef struct {
        int          n;
        logic [7:0]  b[5];
        int          ne;
        logic [23:0] e[2];
    } vec_t;
    vec_t tbl[5];

    initial begin
        tbl[0] = '{3, '{8'h90, 8'h3C, 8'h64, 8'h00, 8'h00}, 1, '{24'h903C64, 24'h0}};
        tbl[1] = '{5, '{8'h90, 8'h3C, 8'h64, 8'h40, 8'h7F}, 2, '{24'h903C64, 24'h90407F}};
        tbl[2] = '{4, '{8'h80, 8'h3C, 8'hF8, 8'h40, 8'h00}, 1, '{24'h803C40, 24'h0}};
        tbl[3] = '{3, '{8'hC5, 8'h07, 8'h09, 8'h00, 8'h00}, 2, '{24'hC50700, 24'hC50900}};
        tbl[4] = '{5, '{8'hF0, 8'h12, 8'h34, 8'h3C, 8'h64}, 0, '{24'h0, 24'h0}};

        repeat (3) @(negedge clk);
        check("reset msg", {8'h0, midi_msg}, 32'h0);
        check("reset rdy", {31'h0, midi_msg_rdy}, 32'h0);
        check("reset frame_err", {31'h0, frame_err}, 32'h0);
        rst_n = 1'b1;
        repeat (BD) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            clear_log();
            for (int k = 0; k < tbl[v].n; k++) send(tbl[v].b[k], 1'b1);
            repeat (4) @(negedge clk);
            check($sformatf("vec%0d count", v), got.size(), tbl[v].ne);
            for (int k = 0; k < tbl[v].ne && k < got.size(); k++)
                check($sformatf("vec%0d msg%0d", v, k), {8'h0, got[k]}, {8'h0, tbl[v].e[k]});
        end
        check("msg held", {8'h0, midi_msg}, 32'h00C50900);

        // latency: pulse one cycle after the stop sample of the last byte
        clear_log();
        send(8'h90, 1'b1);
        send(8'h3C, 1'b1);
        send(8'h64, 1'b1);
        check("latency cycle", first_rdy_cyc, last_start + 3 + BD / 2 + 9 * BD);
        check("latency msg", got.size() > 0 ? {8'h0, got[0]} : 32'hFFFFFFFF, 32'h00903C64);

        // framing error mid-message leaves the partial message intact
        clear_log();
        send(8'h91, 1'b1);
        send(8'h3C, 1'b1);
        send(8'h90, 1'b0);
        check("frame_err count", fe_cnt, 1);
        check("frame_err no msg", got.size(), 0);
        send(8'h64, 1'b1);
        check("after ferr count", got.size(), 1);
        check("after ferr msg", got.size() > 0 ? {8'h0, got[0]} : 32'hFFFFFFFF, 32'h00913C64);

        // short glitch rejected at the start-bit midpoint
        clear_log();
        @(negedge clk);
        midi_rx = 1'b0;
        repeat (BD / 4) @(negedge clk);
        midi_rx = 1'b1;
        repeat (3 * BD) @(negedge clk);
        check("glitch msgs", got.size(), 0);
        check("glitch frame_err", fe_cnt, 0);
        check("glitch msg held", {8'h0, midi_msg}, 32'h00913C64);

        // reset in the middle of a frame
        send(8'h92, 1'b1);
        send(8'h3C, 1'b1);
        @(negedge clk);
        midi_rx = 1'b0;
        repeat (4 * BD) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst msg", {8'h0, midi_msg}, 32'h0);
        check("rst rdy", {31'h0, midi_msg_rdy}, 32'h0);
        check("rst frame_err", {31'h0, frame_err}, 32'h0);
        midi_rx = 1'b1;
        rst_n = 1'b1;
        clear_log();
        repeat (2 * BD) @(negedge clk);
        send(8'h64, 1'b1);
        check("post rst stray data", got.size(), 0);
        send(8'h90, 1'b1);
        send(8'h3C, 1'b1);
        send(8'h64, 1'b1);
        check("post rst count", got.size(), 1);
        check("post rst msg", got.size() > 0 ? {8'h0, got[0]} : 32'hFFFFFFFF, 32'h00903C64);
        check("rdy single cycle", {31'h0, back_to_back}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
